// File: rtl/add32_pipe.sv
// Two-stage pipelined adder (a + b + cin) with valid/ready on both sides.
// Define ADD32_PIPE_OVF_EN to add the registered signed-overflow output out_ovf.
module add32_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADD32_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int HW = WIDTH - SPLIT;

  logic             s1_valid;
  logic [SPLIT:0]   s1_lo;
  logic [HW-1:0]    s1_a_hi;
  logic [HW-1:0]    s1_b_hi;
  logic             s2_valid;
  logic             s2_load;
  logic             in_fire;
  logic             out_fire;
  logic [SPLIT:0]   lo_sum;
  logic [HW:0]      hi_sum;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  assign lo_sum = {1'b0, in_a[SPLIT-1:0]} + {1'b0, in_b[SPLIT-1:0]}
                + {{SPLIT{1'b0}}, in_cin};
  assign hi_sum = {1'b0, s1_a_hi} + {1'b0, s1_b_hi}
                + {{HW{1'b0}}, s1_lo[SPLIT]};

  // The operand MSBs travel in s1_a_hi/s1_b_hi, which the overflow check reuses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_lo    <= lo_sum;
      s1_a_hi  <= in_a[WIDTH-1:SPLIT];
      s1_b_hi  <= in_b[WIDTH-1:SPLIT];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out_sum  <= {hi_sum[HW-1:0], s1_lo[SPLIT-1:0]};
      out_cout <= hi_sum[HW];
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef ADD32_PIPE_OVF_EN
  // Signed overflow: operands share a sign but the result sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (s2_load) begin
      out_ovf <= (s1_a_hi[HW-1] == s1_b_hi[HW-1]) &&
                 (hi_sum[HW-1] != s1_a_hi[HW-1]);
    end
  end
`endif

endmodule
